// File: rtl/shift_reg_ctrl.sv
// Load/shift sequencer for an N-bit parallel-load, right-shift register.
// Serialises the loaded word LSB first over a qualified sout stream.
module shift_reg_ctrl #(
  parameter int N  = 32,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  din,
  input  logic [CW-1:0] amt,
  input  logic          fill,
  input  logic          hold,
  input  logic          reg_lsb,
  output logic [N-1:0]  r,
  output logic          l,
  output logic          e,
  output logic          w,
  output logic          busy,
  output logic          done,
  output logic          sout,
  output logic          sout_valid
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  localparam logic [CW-1:0] NMAX = CW'(N);

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] amt_c;

  // Shifting more than N positions is meaningless; clamp to a full flush.
  assign amt_c = (amt > NMAX) ? NMAX : amt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      r     <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        r   <= din;
        cnt <= amt_c;
      end else if (state == SHIFT && !hold) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  always_comb begin
    nxt        = state;
    l          = 1'b0;
    e          = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) nxt = LOAD;
      end
      LOAD: begin
        l   = 1'b1;
        nxt = (cnt == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        e          = ~hold;
        sout       = reg_lsb;
        sout_valid = ~hold;
        if (!hold && cnt == CW'(1)) nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);
  assign w    = fill;

endmodule

// File: doc/shift_reg_ctrl.md
Name: shift_reg_ctrl

Overview:
Sequencer for the team's N-bit parallel-load / right-shift register. It accepts a word and a shift count over a start/busy handshake, then drives the register's load, enable and serial-in controls: one load cycle, followed by the requested number of shift cycles. While shifting it presents the register's outgoing LSB as a qualified serial stream, so the pair forms a parameterised serializer / barrel-less right shifter. It supports stalling mid-operation and reports completion with a one-cycle done pulse.

Parameters:
N, 32, width of the controlled register's data path
CW, 6, width of the shift-count field; must satisfy 2^CW > N (default covers N=32)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request new operation; accepted only when busy=0
din  input  N  word to load into the register, sampled with accepted start
amt  input  CW  number of right shifts to perform, sampled with accepted start
fill  input  1  bit shifted into register MSB on each shift cycle (passed to w)
hold  input  1  stall: suppresses shifting and freezes the counter while high
reg_lsb  input  1  current q[0] of the controlled register
r  output  N  parallel data to register r input
l  output  1  register load strobe
e  output  1  register shift enable
w  output  1  register serial input
busy  output  1  high from the cycle after start is accepted through DONE
done  output  1  one-cycle completion pulse
sout  output  1  serial output bit (= reg_lsb while sout_valid)
sout_valid  output  1  sout qualifies this cycle

Behaviour:
- States: IDLE, LOAD, SHIFT, DONE. Reset -> IDLE, cnt=0, r=0. All outputs are decoded from state, so with the register zeroed l=e=busy=done=sout_valid=0.
- IDLE: on start=1 at edge, capture r<=din, cnt<=min(amt,N) (clamp), and go to LOAD. start with busy=1 is ignored, with no effect on r or cnt.
- LOAD (1 cycle): l=1, e=0. The register captures r at the end of this cycle.
  - If cnt=0, next state is DONE; else next state is SHIFT.
- SHIFT: e = ~hold, w = fill, sout = reg_lsb, sout_valid = ~hold.
  - On each edge with hold=0: cnt<=cnt-1. When cnt==1 at that edge, next state is DONE.
  - With hold=1: state and cnt unchanged, e=0, sout_valid=0.
- DONE (1 cycle): done=1, busy=1, l=e=0. Next state is IDLE. start is not accepted in DONE.
- busy = (state != IDLE).
- l and e are never high in the same cycle.
- w equals fill in every state (don't-care outside SHIFT) and is a combinational pass-through.
- Latency: accepted start to done = 2 + amt_clamped + (number of hold cycles in SHIFT) cycles.
- Stream order: sout_valid cycle k (k=0..cnt-1) carries din[k], LSB first.
  - After the operation the register holds din >> cnt with the top cnt bits equal to the fill values, in order.
- rst=1 in any state (mid-shift included): at that edge go to IDLE, cnt=0, r=0, and all strobes low the next cycle. The register contents are left as-is; the controller does not clear them.
- hold in IDLE, LOAD or DONE has no effect. hold=1 on the final count cycle delays DONE until hold drops.
- start=1 held continuously: a new operation is accepted in the first IDLE cycle after DONE, giving back-to-back operations with a one-cycle IDLE gap.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, start=0 -> l=e=busy=done=sout_valid=0, r=0.
- Basic shift: N=32, din=32'hA5A5_0003, amt=4, fill=0, hold=0 -> l high 1 cycle, then e high 4 cycles. sout sequence 1,1,0,0, done on cycle 6 after start. Register = 32'h0A5A_5000.
- Zero and clamp: amt=0 -> LOAD then DONE with no e cycles and register = din. amt=40 (N=32) -> exactly 32 e cycles, and with fill=1 the register = 32'hFFFF_FFFF.
- Stall: amt=3, hold=1 on the 2nd SHIFT cycle for 2 cycles -> e pattern 1,0,0,1,1. sout_valid matches e, stream = din[0..2] unbroken, done delayed by 2 cycles.
- Ignored start and back-to-back: pulse start with din=32'h1 mid-SHIFT -> no change to r/cnt. Hold start=1 continuously with amt=2 -> second LOAD occurs exactly 2 cycles after the first done.
- Reset mid-operation: rst=1 during 3rd of 8 SHIFT cycles -> next cycle IDLE with busy=0, e=0 and no done pulse. A new start afterwards runs a full 8-shift operation normally.
